beep_pattern_gen: RTL and testbench

Output-side counterpart to the button front end: turns a single-cycle event pulse into a timed, tick-paced on/off pattern of 1–7 beeps for a buzzer or LED. It sits between the control FSM, which issues one-clock trigger pulses, and the board buzzer/LED pin. It shares the system `tick` strobe (1 ms) used by the debouncers.

---
 rtl/beep_pattern_gen_pkg.sv | 25 ++
 rtl/beep_pattern_gen_tick_timer.sv | 31 +++
 rtl/beep_pattern_gen.sv | 126 ++++++++++++
 tb/tb_beep_pattern_gen.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/beep_pattern_gen_pkg.sv
// Shared constants and types for the beep pattern generator.
// Holds the state encoding, the default 1 ms-tick phase lengths and a beep-count helper.
package beep_pattern_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2
    } beep_state_t;

    localparam int DEF_ON_TICKS  = 100;
    localparam int DEF_OFF_TICKS = 100;

    // A request for zero beeps still produces one beep.
    function automatic logic [2:0] norm_beep_num(input logic [2:0] num);
        logic [2:0] res;
        if (num == 3'd0) begin
            res = 3'd1;
        end else begin
            res = num;
        end
        return res;
    endfunction

endpackage

// File: rtl/beep_pattern_gen_tick_timer.sv
// Loadable tick counter: counts ticks and flags the tick that ends a phase.
// The count returns to zero on clear, on reset and on the expiring tick itself.
module beep_tick_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             tick,
    input  logic [CNT_W-1:0] limit,
    output logic             expire
);

    logic [CNT_W-1:0] cnt_r;

    assign expire = tick && (cnt_r == (limit - {{(CNT_W-1){1'b0}}, 1'b1}));

    // Tick count within the current phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (clr || expire) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (tick) begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/beep_pattern_gen.sv
// Turns a one-clock trigger into 1-7 tick-timed beeps on a registered output.
// Cancel and reset both abort immediately without a completion pulse.
module beep_pattern_gen
    import beep_pattern_gen_pkg::*;
#(
    parameter int ON_TICKS  = DEF_ON_TICKS,
    parameter int OFF_TICKS = DEF_OFF_TICKS,
    parameter int CNT_W     = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       trigPulse,
    input  logic [2:0] beepNum,
    input  logic       cancel,
    output logic       beepOut,
    output logic       busy,
    output logic       donePulse
);

    localparam logic [CNT_W-1:0] ON_LIM  = CNT_W'(ON_TICKS);
    localparam logic [CNT_W-1:0] OFF_LIM = CNT_W'(OFF_TICKS);

    beep_state_t      state_r;
    logic [2:0]       rem_r;
    logic             beep_r;
    logic             busy_r;
    logic             done_r;
    logic             clr_s;
    logic             expire_s;
    logic [CNT_W-1:0] limit_s;

    // Idle holds the counter at zero so every pattern starts from a fresh count.
    assign clr_s   = cancel || (state_r == ST_IDLE);
    assign limit_s = (state_r == ST_ON) ? ON_LIM : OFF_LIM;

    beep_tick_timer #(
        .CNT_W(CNT_W)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr_s),
        .tick  (tick),
        .limit (limit_s),
        .expire(expire_s)
    );

    // Pattern FSM with registered outputs that follow the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            rem_r   <= 3'd0;
            beep_r  <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (trigPulse && !cancel) begin
                        state_r <= ST_ON;
                        rem_r   <= norm_beep_num(beepNum);
                        beep_r  <= 1'b1;
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                        rem_r   <= 3'd0;
                        beep_r  <= 1'b0;
                        busy_r  <= 1'b0;
                    end
                end
                ST_ON: begin
                    if (cancel) begin
                        state_r <= ST_IDLE;
                        rem_r   <= 3'd0;
                        beep_r  <= 1'b0;
                        busy_r  <= 1'b0;
                    end else if (expire_s) begin
                        beep_r <= 1'b0;
                        if (rem_r == 3'd1) begin
                            state_r <= ST_IDLE;
                            rem_r   <= 3'd0;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                        end else begin
                            state_r <= ST_OFF;
                            rem_r   <= rem_r - 3'd1;
                            busy_r  <= 1'b1;
                        end
                    end else begin
                        state_r <= ST_ON;
                        beep_r  <= 1'b1;
                        busy_r  <= 1'b1;
                    end
                end
                ST_OFF: begin
                    if (cancel) begin
                        state_r <= ST_IDLE;
                        rem_r   <= 3'd0;
                        beep_r  <= 1'b0;
                        busy_r  <= 1'b0;
                    end else if (expire_s) begin
                        state_r <= ST_ON;
                        beep_r  <= 1'b1;
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= ST_OFF;
                        beep_r  <= 1'b0;
                        busy_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    rem_r   <= 3'd0;
                    beep_r  <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign beepOut   = beep_r;
    assign busy      = busy_r;
    assign donePulse = done_r;

endmodule

// File: tb/tb_beep_pattern_gen.sv
// Directed bench for beep_pattern_gen (ON_TICKS=3, OFF_TICKS=2, tick every 4 clocks).
// Expected outputs come from a phase/tick reference model queued per cycle.
module tb_beep_pattern_gen;

    localparam int ON_T  = 3;
    localparam int OFF_T = 2;

    typedef struct packed {
        logic beep;
        logic busy;
        logic done;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       trigPulse = 1'b0;
    logic [2:0] beepNum = 3'd0;
    logic       cancel = 1'b0;
    logic       beepOut;
    logic       busy;
    logic       donePulse;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int m_ph = 0;
    int m_cnt = 0;
    int m_rem = 0;
    int rises = 0;
    int dones = 0;
    int gaps = 0;
    int hi_cyc = 0;
    logic prev_beep = 1'b0;
    exp_t sb[$];

    beep_pattern_gen #(.ON_TICKS(ON_T), .OFF_TICKS(OFF_T), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .tick(tick), .trigPulse(trigPulse),
        .beepNum(beepNum), .cancel(cancel), .beepOut(beepOut),
        .busy(busy), .donePulse(donePulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        rises = 0; dones = 0; gaps = 0; hi_cyc = 0;
    endtask

    // Drive one cycle, advance the reference model, then compare after the edge.
    task automatic step(input logic t, input logic [2:0] n, input logic c, input logic r);
        exp_t e;
        exp_t got;
        trigPulse = t; beepNum = n; cancel = c; rst = r;
        tick = ((cyc % 4) == 3);
        e.done = 1'b0;
        if (r) begin
            m_ph = 0; m_cnt = 0; m_rem = 0;
        end else if (m_ph == 0) begin
            if (t && !c) begin
                m_rem = (n == 3'd0) ? 1 : int'(n);
                m_cnt = 0; m_ph = 1;
            end
        end else if (c) begin
            m_ph = 0; m_cnt = 0; m_rem = 0;
        end else if (tick) begin
            if (m_cnt == ((m_ph == 1) ? ON_T - 1 : OFF_T - 1)) begin
                m_cnt = 0;
                if (m_ph == 2) begin
                    m_ph = 1;
                end else if (m_rem == 1) begin
                    m_ph = 0; m_rem = 0; e.done = 1'b1;
                end else begin
                    m_rem--; m_ph = 2;
                end
            end else begin
                m_cnt++;
            end
        end
        e.beep = (m_ph == 1);
        e.busy = (m_ph != 0);
        sb.push_back(e);
        @(posedge clk);
        #1;
        cyc++;
        got = sb.pop_front();
        check("beepOut", int'(beepOut), int'(got.beep));
        check("busy", int'(busy), int'(got.busy));
        check("donePulse", int'(donePulse), int'(got.done));
        if (beepOut && !prev_beep) rises++;
        if (!beepOut && prev_beep && busy) gaps++;
        if (beepOut) hi_cyc++;
        if (donePulse) dones++;
        prev_beep = beepOut;
    endtask

    task automatic idle(input int ncyc);
        for (int i = 0; i < ncyc; i++) step(1'b0, 3'd0, 1'b0, 1'b0);
    endtask

    task automatic run_until_idle(input string tag);
        for (int i = 0; i < 300; i++) begin
            step(1'b0, 3'd0, 1'b0, 1'b0);
            if (!busy) break;
        end
        check(tag, int'(busy), 0);
    endtask

    initial begin
        // 1: reset then single beep
        for (int i = 0; i < 3; i++) step(1'b0, 3'd0, 1'b0, 1'b1);
        check("rst_beep", int'(beepOut), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(donePulse), 0);
        idle(2);
        clear_stats();
        step(1'b1, 3'd1, 1'b0, 1'b0);
        check("s1_busy_next", int'(busy), 1);
        check("s1_beep_next", int'(beepOut), 1);
        run_until_idle("s1_timeout");
        check("s1_rises", rises, 1);
        check("s1_dones", dones, 1);
        check("s1_hi_range", int'(hi_cyc >= (ON_T - 1) * 4 + 1 && hi_cyc <= ON_T * 4 + 1), 1);
        idle(3);

        // 2: three beeps
        clear_stats();
        step(1'b1, 3'd3, 1'b0, 1'b0);
        run_until_idle("s2_timeout");
        check("s2_rises", rises, 3);
        check("s2_gaps", gaps, 2);
        check("s2_dones", dones, 1);
        idle(5);

        // 3: zero count behaves as one
        clear_stats();
        step(1'b1, 3'd0, 1'b0, 1'b0);
        run_until_idle("s3_timeout");
        check("s3_rises", rises, 1);
        check("s3_dones", dones, 1);
        check("s3_hi_range", int'(hi_cyc >= (ON_T - 1) * 4 + 1 && hi_cyc <= ON_T * 4 + 1), 1);
        idle(2);

        // 4: retrigger while busy is ignored, retrigger on done is immediate
        clear_stats();
        step(1'b1, 3'd2, 1'b0, 1'b0);
        for (int i = 0; i < 200 && rises < 2; i++) step(1'b0, 3'd0, 1'b0, 1'b0);
        check("s4_second_beep", rises, 2);
        step(1'b1, 3'd5, 1'b0, 1'b0);
        for (int i = 0; i < 200 && !donePulse; i++) step(1'b0, 3'd0, 1'b0, 1'b0);
        check("s4_done_seen", int'(donePulse), 1);
        check("s4_rises", rises, 2);
        step(1'b1, 3'd1, 1'b0, 1'b0);
        check("s4_restart_busy", int'(busy), 1);
        check("s4_restart_beep", int'(beepOut), 1);
        run_until_idle("s4_timeout");
        check("s4_dones", dones, 2);
        idle(3);

        // 5: cancel during OFF, then cancel with trigger in idle
        clear_stats();
        step(1'b1, 3'd2, 1'b0, 1'b0);
        for (int i = 0; i < 200 && gaps < 1; i++) step(1'b0, 3'd0, 1'b0, 1'b0);
        check("s5_in_off", int'(busy && !beepOut), 1);
        step(1'b0, 3'd0, 1'b1, 1'b0);
        check("s5_cancel_busy", int'(busy), 0);
        check("s5_cancel_beep", int'(beepOut), 0);
        idle(20);
        check("s5_no_done", dones, 0);
        clear_stats();
        step(1'b1, 3'd3, 1'b1, 1'b0);
        check("s5_both_busy", int'(busy), 0);
        idle(20);
        check("s5_both_rises", rises, 0);

        // 6: reset mid-pattern, then full fresh pattern
        step(1'b1, 3'd2, 1'b0, 1'b0);
        idle(4);
        check("s6_in_on", int'(beepOut), 1);
        step(1'b0, 3'd0, 1'b0, 1'b1);
        check("s6_rst_beep", int'(beepOut), 0);
        check("s6_rst_busy", int'(busy), 0);
        check("s6_rst_done", int'(donePulse), 0);
        idle(2);
        clear_stats();
        step(1'b1, 3'd1, 1'b0, 1'b0);
        run_until_idle("s6_timeout");
        check("s6_rises", rises, 1);
        check("s6_dones", dones, 1);
        check("s6_hi_range", int'(hi_cyc >= (ON_T - 1) * 4 + 1 && hi_cyc <= ON_T * 4 + 1), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
